// File: rtl/act_stream_buffer.sv
// Absorbs a valid-only activation stream into a FIFO and re-issues it on valid/ready,
// tagging row ends and flagging drops. Optional almost_full port: ACT_STREAM_BUFFER_AFULL_EN.
module act_stream_buffer #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned ROW_LEN = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     valid_in,
    input  logic [DATA_W-1:0]        data_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_last,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
`ifdef ACT_STREAM_BUFFER_AFULL_EN
    output logic                     almost_full,
`endif
    input  logic                     clr_ovf
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned CNT_W = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;

    logic [DATA_W:0]    mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   row_cnt;
    logic [LVL_W-1:0]   level_nxt;
    logic               full;
    logic               empty;
    logic               pop;
    logic               push;
    logic               drop;
    logic               row_last;

    assign full     = (level == LVL_W'(DEPTH));
    assign empty    = (level == '0);
    assign pop      = out_valid && out_ready;
    assign push     = valid_in && (!full || pop);
    assign drop     = valid_in && full && !pop;
    assign row_last = (row_cnt == CNT_W'(ROW_LEN - 1));

    // Head is read straight from storage; forced to zero while empty.
    assign out_data = empty ? '0 : mem[rd_ptr][DATA_W-1:0];
    assign out_last = empty ? 1'b0 : mem[rd_ptr][DATA_W];

    always_comb begin
        level_nxt = level;
        if (push && !pop) begin
            level_nxt = level + LVL_W'(1);
        end else if (pop && !push) begin
            level_nxt = level - LVL_W'(1);
        end
    end

    // Storage is deliberately not reset; empty masking hides stale contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {row_last, data_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            out_valid <= 1'b0;
            row_cnt   <= '0;
            overflow  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level     <= level_nxt;
            out_valid <= (level_nxt != '0);
            // Row position follows the producer, so dropped beats still count.
            if (valid_in) begin
                row_cnt <= row_last ? '0 : row_cnt + CNT_W'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef ACT_STREAM_BUFFER_AFULL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            almost_full <= 1'b0;
        end else begin
            almost_full <= (level_nxt >= LVL_W'(DEPTH - 2));
        end
    end
`endif

endmodule

// File: tb/tb_act_stream_buffer.sv
// Directed bench for act_stream_buffer with a queue scoreboard of expected {last, data}.
module tb_act_stream_buffer;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned ROW_LEN = 4;

    logic              clk;
    logic              rst_n;
    logic              valid_in;
    logic [DATA_W-1:0] data_in;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic [4:0]        level;
    logic              overflow;
    logic              clr_ovf;
`ifdef ACT_STREAM_BUFFER_AFULL_EN
    logic              almost_full;
`endif

    act_stream_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ROW_LEN(ROW_LEN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_in   (valid_in),
        .data_in    (data_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .level      (level),
        .overflow   (overflow),
`ifdef ACT_STREAM_BUFFER_AFULL_EN
        .almost_full(almost_full),
`endif
        .clr_ovf    (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int          vectors = 0;
    int          miscompares = 0;
    logic [32:0] sb [$];
    int          m_row = 0;
    logic        m_ovf = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Evaluated mid-cycle: checks state from previous edges, then predicts the coming edge.
    task automatic model_step();
        int          sz;
        logic        pop;
        logic        drop;
        logic [32:0] exp;
        sz   = sb.size();
        drop = 1'b0;
        chk("level", 64'(level), 64'(sz));
        chk("out_valid", 64'(out_valid), 64'(sz != 0));
        chk("overflow", 64'(overflow), 64'(m_ovf));
`ifdef ACT_STREAM_BUFFER_AFULL_EN
        chk("almost_full", 64'(almost_full), 64'(sz >= int'(DEPTH) - 2));
`endif
        if (sz == 0) begin
            chk("empty_data", 64'(out_data), 64'd0);
            chk("empty_last", 64'(out_last), 64'd0);
        end
        pop = (sz != 0) && out_ready;
        if (pop) begin
            exp = sb.pop_front();
            chk("out_data", 64'(out_data), 64'(exp[31:0]));
            chk("out_last", 64'(out_last), 64'(exp[32]));
        end
        if (valid_in) begin
            if (sz < int'(DEPTH) || pop) begin
                sb.push_back({(m_row == int'(ROW_LEN) - 1), data_in});
            end else begin
                drop = 1'b1;
            end
            m_row = (m_row + 1) % int'(ROW_LEN);
        end
        if (drop) m_ovf = 1'b1;
        else if (clr_ovf) m_ovf = 1'b0;
    endtask

    task automatic cyc();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_n(input int n, input logic [31:0] base, input logic rdy);
        for (int i = 0; i < n; i++) begin
            valid_in  = 1'b1;
            data_in   = base + 32'(i);
            out_ready = rdy;
            cyc();
        end
        valid_in = 1'b0;
    endtask

    task automatic idle_n(input int n, input logic rdy);
        valid_in  = 1'b0;
        out_ready = rdy;
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        int k;
        rst_n     = 1'b0;
        valid_in  = 1'b0;
        data_in   = '0;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
        #12;
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Fill 1..8 with consumer stalled, then drain.
        push_n(8, 32'h1, 1'b0);
        chk("fill_level8", 64'(level), 64'd8);
        idle_n(10, 1'b1);

        // Overflow: 18 beats into 16 entries, drain, clear.
        push_n(18, 32'h100, 1'b0);
        chk("ovf_set", 64'(overflow), 64'd1);
        idle_n(18, 1'b1);
        clr_ovf = 1'b1;
        cyc();
        clr_ovf = 1'b0;
        idle_n(2, 1'b0);

        // Full pass-through across pointer wrap.
        push_n(16, 32'h200, 1'b0);
        push_n(10, 32'h300, 1'b1);
        chk("pass_level", 64'(level), 64'd16);
        idle_n(18, 1'b1);

        // Row alignment: fill so the dropped beat is the 4th of its row.
        k = (int'(ROW_LEN) - 1 - m_row + int'(ROW_LEN)) % int'(ROW_LEN);
        if (k > 0) push_n(k, 32'h400, 1'b1);
        idle_n(2, 1'b1);
        push_n(16, 32'h500, 1'b0);
        push_n(1, 32'h5FF, 1'b0);
        idle_n(18, 1'b1);
        push_n(4, 32'h600, 1'b1);
        idle_n(3, 1'b1);

        // Latency: single beat into empty FIFO with consumer ready.
        push_n(1, 32'hDEADBEEF, 1'b1);
        chk("lat_valid", 64'(out_valid), 64'd1);
        chk("lat_data", 64'(out_data), 64'hDEADBEEF);
        cyc();
        chk("lat_after_valid", 64'(out_valid), 64'd0);
        chk("lat_after_data", 64'(out_data), 64'd0);

        // Async reset mid-cycle with 5 entries and overflow still set.
        push_n(5, 32'h700, 1'b0);
        chk("pre_rst_level", 64'(level), 64'd5);
        chk("pre_rst_ovf", 64'(overflow), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_level", 64'(level), 64'd0);
        chk("arst_overflow", 64'(overflow), 64'd0);
        sb.delete();
        m_row = 0;
        m_ovf = 1'b0;
        idle_n(1, 1'b0);
        rst_n = 1'b1;
        push_n(8, 32'h800, 1'b1);
        idle_n(3, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/act_stream_buffer.md
Name: act_stream_buffer

Overview:
- Downstream stage of the elementwise activation units (GELU and similar). Those units emit a valid-only 32-bit stream with no backpressure.
- This block absorbs that stream into a small FIFO and re-issues it on a valid/ready interface to the next consumer (reduction / writeback).
- Tags the final element of every row with a last flag and records overflow when the consumer stalls too long.

Parameters:
- DATA_W, 32, element width (matches activation output).
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- ROW_LEN, 64, elements per row for last-flag generation; minimum 1.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- valid_in  in  1  input beat strobe from activation stage.
- data_in  in  DATA_W  input element.
- out_valid  out  1  FIFO non-empty, head entry presented.
- out_ready  in  1  consumer accepts head when out_valid high.
- out_data  out  DATA_W  head element.
- out_last  out  1  head element is the last of its row.
- level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: an input beat was dropped.
- clr_ovf  in  1  synchronous clear of overflow.

Behaviour:
- Reset (async assert, sync-released use): FIFO empty, rd/wr pointers 0, level 0, row counter 0, overflow 0. Outputs out_valid=0, out_last=0, out_data=0 (storage array is not reset; out_data is forced 0 while empty).
- Storage: DEPTH x (DATA_W+1) register array; bit DATA_W holds the last tag.
- Pop occurs when out_valid && out_ready.
- Push occurs when valid_in && (!full || pop).
  - Simultaneous push+pop when full is legal: level unchanged.
  - Simultaneous push+pop when empty pushes only; there is no bypass.
- Latency: a beat pushed at edge N drives out_valid=1 and its data/last after edge N (one cycle).
- First-word-fall-through: out_data/out_last are read combinationally from mem[rd_ptr].
- Pointers: $clog2(DEPTH) bits, wrap naturally modulo DEPTH. Full/empty are derived from level (level==DEPTH, level==0).
- level: +1 on push only, -1 on pop only, unchanged on both or neither.
- Row counter:
  - Advances on every valid_in beat, accepted or dropped, so row alignment tracks the producer.
  - The tag is last = (row_cnt == ROW_LEN-1).
  - The counter wraps to 0 after ROW_LEN-1. With ROW_LEN==1, every beat is last.
- Drop: valid_in && full && !pop. The element is discarded, overflow is set next edge, and the row counter still advances.
- overflow:
  - Sticky until clr_ovf.
  - If clr_ovf and a new drop occur in the same cycle, overflow stays 1 (set wins).
- out_ready while empty is ignored; no underflow, no state change.
- out_valid never deasserts while the head is unconsumed; head data is stable until popped.
- Reset mid-stream discards all contents immediately (async), including a partial row.

Optional Feature:
- Macro: ACT_STREAM_BUFFER_AFULL_EN.
- Defined: adds output port almost_full (1 bit).
  - almost_full is registered; it is 1 when post-update level >= DEPTH-2, and resets to 0.
  - Lets the upstream scheduler throttle issue before a drop happens.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Fill/drain: DEPTH=16, ROW_LEN=4. Push 0x1..0x8 with out_ready=0, then out_ready=1.
  - level reaches 8.
  - Outputs 0x1..0x8 in order.
  - out_last=1 on 0x4 and 0x8 only.
  - level returns to 0, out_valid=0.
- Overflow: out_ready=0, push 18 beats.
  - level=16; beats 17 and 18 are dropped; overflow=1.
  - After draining, the 16 outputs are beats 1..16.
  - clr_ovf pulse gives overflow=0.
- Full pass-through: FIFO full, valid_in=1 and out_ready=1 for 10 cycles.
  - No drops, overflow stays 0, level stays 16.
  - Output order is preserved across pointer wrap.
- Row alignment after drop: ROW_LEN=4, force a drop of the 4th beat of a row.
  - No last is emitted for that row.
  - The next row's 4th beat has out_last=1.
- Latency/empty: single push of 0xDEADBEEF on an empty FIFO with out_ready=1.
  - out_valid=1 exactly one cycle after the push edge, out_data=0xDEADBEEF.
  - Popped that cycle; then out_valid=0 and out_data=0.
- Async reset: assert rst_n=0 mid-cycle with level=5.
  - out_valid, level and overflow go to 0 immediately.
  - The row counter restarts at 0, so the 4th post-reset beat is last (ROW_LEN=4).
